// File: rtl/hazard_pkg.sv
// Shared definitions for the forwarding/hazard unit: forward-select
// encodings, register-address width, the per-stage tracking record and
// the operand-forwarding priority function.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  load;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } stage_t;

  // Memory stage wins over Writeback; x0 and non-writing stages never forward.
  function automatic fwd_sel_e fwd_select(input logic [REG_ADDR_W-1:0] rs,
                                          input stage_t m,
                                          input stage_t w);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (m.reg_write && (m.rd != '0) && (m.rd == rs)) begin
      sel = FWD_MEM;
    end else if (w.reg_write && (w.rd != '0) && (w.rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline tracking stage: holds a stage_t record, loads a bubble
// when 'clear' is high and clears on synchronous reset.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  stage_t d,
  output stage_t q
);

  stage_t state_d;
  stage_t state_q;

  // Next record is the upstream record, or an all-zero bubble when cleared.
  always_comb begin
    state_d = d;
    if (clear) begin
      state_d = '0;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and hazard-detection unit for a five-stage pipeline.
// Tracks destination/source info through E, M and W, selects Execute
// operand bypasses, and raises load-use stalls and branch flushes.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush
// event counters (stall_cnt, flush_cnt).
module forward_hazard_unit
  import hazard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  reg_write_d,
  input  logic                  load_d,
  input  logic                  pc_src_e,
  output logic [1:0]            forward_ae,
  output logic [1:0]            forward_be,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  stage_t   dec_rec;
  stage_t   e_q;
  stage_t   m_q;
  stage_t   w_q;
  logic     lwstall;
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;
  logic     unused_w_fields;

  // Pack the Decode-stage instruction into a tracking record.
  always_comb begin
    dec_rec           = '0;
    dec_rec.rd        = rd_d;
    dec_rec.reg_write = reg_write_d;
    dec_rec.load      = load_d;
    dec_rec.rs1       = rs1_d;
    dec_rec.rs2       = rs2_d;
  end

  hazard_stage_reg u_stage_e (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_e),
    .d     (dec_rec),
    .q     (e_q)
  );

  hazard_stage_reg u_stage_m (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .d     (e_q),
    .q     (m_q)
  );

  hazard_stage_reg u_stage_w (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .d     (m_q),
    .q     (w_q)
  );

  // Writeback only needs rd/reg_write; the remaining fields ride along unused.
  assign unused_w_fields = ^{w_q.load, w_q.rs1, w_q.rs2};

  // Load-use detection; a taken branch overrides the stall but both flushes fire.
  always_comb begin
    lwstall = e_q.load && (e_q.rd != '0) &&
              ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));
    stall_f = lwstall && !pc_src_e;
    stall_d = lwstall && !pc_src_e;
    flush_d = pc_src_e;
    flush_e = lwstall || pc_src_e;
  end

  // Operand bypass selects depend only on registered E/M/W state.
  always_comb begin
    fwd_a      = fwd_select(e_q.rs1, m_q, w_q);
    fwd_b      = fwd_select(e_q.rs2, m_q, w_q);
    forward_ae = fwd_a;
    forward_be = fwd_b;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_d;
  logic [31:0] flush_cnt_q;

  // Saturating event counters for stall cycles and taken-branch cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (pc_src_e && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit. Each row drives one Decode
// instruction and carries the expected output word for that same cycle,
// packed as {forward_ae, forward_be, stall_f, stall_d, flush_d, flush_e}.
module tb_forward_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [4:0] rd_d;
  logic       reg_write_d;
  logic       load_d;
  logic       pc_src_e;
  logic [1:0] forward_ae;
  logic [1:0] forward_be;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string      name;
    logic       chk;
    logic       r;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       pc;
    logic [7:0] expv;
  } vec_t;

  vec_t sb[$];

  wire [7:0] obs = {forward_ae, forward_be, stall_f, stall_d, flush_d, flush_e};

  forward_hazard_unit dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rd_d        (rd_d),
    .reg_write_d (reg_write_d),
    .load_d      (load_d),
    .pc_src_e    (pc_src_e),
    .forward_ae  (forward_ae),
    .forward_be  (forward_be),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic vec_t mkv(input string name, input logic chk, input logic r,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic rw, input logic ld,
                               input logic pc, input logic [7:0] expv);
    vec_t v;
    v.name = name; v.chk = chk; v.r = r; v.rs1 = rs1; v.rs2 = rs2;
    v.rd = rd; v.rw = rw; v.ld = ld; v.pc = pc; v.expv = expv;
    return v;
  endfunction

  // Drive one row at the falling edge and queue its expected outputs.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst         = v.r;
    rs1_d       = v.rs1;
    rs2_d       = v.rs2;
    rd_d        = v.rd;
    reg_write_d = v.rw;
    load_d      = v.ld;
    pc_src_e    = v.pc;
    sb.push_back(v);
  endtask

  task automatic test_reset();
    vec_t tbl[$];
    vec_t e;
    tbl.push_back(mkv("rst_init",    0, 1, 0, 0, 0, 0, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("rst_hold",    1, 1, 0, 0, 4, 1, 1, 0, 8'b00_00_0000));
    tbl.push_back(mkv("rst_branch",  1, 1, 4, 0, 6, 1, 0, 1, 8'b00_00_0011));
    tbl.push_back(mkv("rst_release", 1, 0, 0, 0, 0, 0, 0, 0, 8'b00_00_0000));
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      #1;
      e = sb.pop_front();
      if (e.chk) begin
        vectors++;
        if (obs !== e.expv) begin
          miscompares++;
          $display("[TB] FAIL %s: got fa_fb_sf_sd_fd_fe=%b, expected %b", e.name, obs, e.expv);
        end
      end
    end
  endtask

  task automatic test_mem_forward();
    vec_t tbl[$];
    vec_t e;
    tbl.push_back(mkv("mem_pre",   0, 1, 0, 0, 0, 0, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("mem_add",   1, 0, 1, 2, 5, 1, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("mem_sub",   1, 0, 5, 3, 6, 1, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("mem_fwd",   1, 0, 0, 0, 0, 0, 0, 0, 8'b10_00_0000));
    tbl.push_back(mkv("mem_drain", 1, 0, 0, 0, 0, 0, 0, 0, 8'b00_00_0000));
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      #1;
      e = sb.pop_front();
      if (e.chk) begin
        vectors++;
        if (obs !== e.expv) begin
          miscompares++;
          $display("[TB] FAIL %s: got fa_fb_sf_sd_fd_fe=%b, expected %b", e.name, obs, e.expv);
        end
      end
    end
  endtask

  task automatic test_wb_forward();
    vec_t tbl[$];
    vec_t e;
    tbl.push_back(mkv("wb_pre",   0, 1, 0, 0, 0,  0, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("wb_def7",  1, 0, 1, 1, 7,  1, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("wb_indep", 1, 0, 1, 2, 8,  1, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("wb_use",   1, 0, 3, 7, 10, 1, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("wb_fwd",   1, 0, 0, 0, 0,  0, 0, 0, 8'b00_01_0000));
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      #1;
      e = sb.pop_front();
      if (e.chk) begin
        vectors++;
        if (obs !== e.expv) begin
          miscompares++;
          $display("[TB] FAIL %s: got fa_fb_sf_sd_fd_fe=%b, expected %b", e.name, obs, e.expv);
        end
      end
    end
  endtask

  task automatic test_priority();
    vec_t tbl[$];
    vec_t e;
    tbl.push_back(mkv("pri_pre", 0, 1, 0, 0, 0,  0, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("pri_w1",  1, 0, 0, 0, 9,  1, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("pri_w2",  1, 0, 0, 0, 9,  1, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("pri_use", 1, 0, 9, 9, 11, 1, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("pri_fwd", 1, 0, 0, 0, 0,  0, 0, 0, 8'b10_10_0000));
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      #1;
      e = sb.pop_front();
      if (e.chk) begin
        vectors++;
        if (obs !== e.expv) begin
          miscompares++;
          $display("[TB] FAIL %s: got fa_fb_sf_sd_fd_fe=%b, expected %b", e.name, obs, e.expv);
        end
      end
    end
  endtask

  task automatic test_load_use();
    vec_t tbl[$];
    vec_t e;
    tbl.push_back(mkv("lu_pre",       0, 1, 0, 0,  0,  0, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("lu_lw",        1, 0, 2, 0,  4,  1, 1, 0, 8'b00_00_0000));
    tbl.push_back(mkv("lu_stall",     1, 0, 4, 1,  6,  1, 0, 0, 8'b00_00_1101));
    tbl.push_back(mkv("lu_held",      1, 0, 4, 1,  6,  1, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("lu_fwd",       1, 0, 0, 0,  0,  0, 0, 0, 8'b01_00_0000));
    tbl.push_back(mkv("lu_lw2",       1, 0, 0, 0,  11, 1, 1, 0, 8'b00_00_0000));
    tbl.push_back(mkv("lu_stall_rs2", 1, 0, 0, 11, 12, 1, 0, 0, 8'b00_00_1101));
    tbl.push_back(mkv("lu_held2",     1, 0, 0, 11, 12, 1, 0, 0, 8'b00_00_0000));
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      #1;
      e = sb.pop_front();
      if (e.chk) begin
        vectors++;
        if (obs !== e.expv) begin
          miscompares++;
          $display("[TB] FAIL %s: got fa_fb_sf_sd_fd_fe=%b, expected %b", e.name, obs, e.expv);
        end
      end
    end
  endtask

  task automatic test_branch_wins();
    vec_t tbl[$];
    vec_t e;
    tbl.push_back(mkv("br_pre",   0, 1, 0, 0, 0, 0, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("br_lw",    1, 0, 0, 0, 4, 1, 1, 0, 8'b00_00_0000));
    tbl.push_back(mkv("br_wins",  1, 0, 4, 0, 6, 1, 0, 1, 8'b00_00_0011));
    tbl.push_back(mkv("br_after", 1, 0, 0, 0, 0, 0, 0, 0, 8'b00_00_0000));
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      #1;
      e = sb.pop_front();
      if (e.chk) begin
        vectors++;
        if (obs !== e.expv) begin
          miscompares++;
          $display("[TB] FAIL %s: got fa_fb_sf_sd_fd_fe=%b, expected %b", e.name, obs, e.expv);
        end
      end
    end
  endtask

  task automatic test_x0_and_midreset();
    vec_t tbl[$];
    vec_t e;
    tbl.push_back(mkv("x0_pre",       0, 1, 0,  0, 0,  0, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("x0_lw",        1, 0, 0,  0, 0,  1, 1, 0, 8'b00_00_0000));
    tbl.push_back(mkv("x0_use",       1, 0, 0,  0, 3,  1, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("x0_nofwd",     1, 0, 0,  0, 12, 0, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("x0_rwuse",     1, 0, 12, 0, 0,  0, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("x0_rwchk",     1, 0, 0,  0, 13, 1, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("x0_rst",       1, 1, 13, 0, 0,  0, 0, 0, 8'b00_00_0000));
    tbl.push_back(mkv("x0_after_rst", 1, 0, 0,  0, 0,  0, 0, 0, 8'b00_00_0000));
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      #1;
      e = sb.pop_front();
      if (e.chk) begin
        vectors++;
        if (obs !== e.expv) begin
          miscompares++;
          $display("[TB] FAIL %s: got fa_fb_sf_sd_fd_fe=%b, expected %b", e.name, obs, e.expv);
        end
      end
    end
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    rst         = 1'b1;
    rs1_d       = '0;
    rs2_d       = '0;
    rd_d        = '0;
    reg_write_d = 1'b0;
    load_d      = 1'b0;
    pc_src_e    = 1'b0;
    test_reset();
    test_mem_forward();
    test_wb_forward();
    test_priority();
    test_load_use();
    test_branch_wins();
    test_x0_and_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
